bnn_layer_seq: RTL

//  Parametrised binary-neural-network layer: N_OUT neurons, each computing
//  y[j] = popcount(XNOR(x, w[j])) >= thr[j]. Weights and thresholds are loaded

---
 rtl/bnn_pkg.sv | 34 +++
 rtl/bnn_neuron.sv | 26 ++
 rtl/bnn_layer_seq.sv | 132 +++++++++++++
 3 files changed

// File: rtl/bnn_pkg.sv
// Shared types and sizing helpers for the binary-neural-network layer.
package bnn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EVAL = 2'd2,
    DONE = 2'd3
  } state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Counter width able to hold a popcount of 0..n_in.
  function automatic int unsigned cnt_w(input int unsigned n_in);
    return clog2(n_in + 1);
  endfunction

  // Bits per neuron record: {thr, w}.
  function automatic int unsigned rec_w(input int unsigned n_in);
    return n_in + cnt_w(n_in);
  endfunction

endpackage

// File: rtl/bnn_neuron.sv
// Combinational binary neuron: popcount(XNOR(x, w)) >= thr, unsigned.
module bnn_neuron #(
  parameter int unsigned N_IN  = 6,
  parameter int unsigned CNT_W = 3
) (
  input  logic [N_IN-1:0]  x,
  input  logic [N_IN-1:0]  w,
  input  logic [CNT_W-1:0] thr,
  output logic             fire_c
);

  logic [N_IN-1:0]  match;
  logic [CNT_W-1:0] cnt;

  // XNOR agreement count, then threshold compare
  always_comb begin
    match  = ~(x ^ w);
    cnt    = '0;
    fire_c = 1'b0;
    for (int i = 0; i < int'(N_IN); i++) begin
      cnt = cnt + CNT_W'(match[i]);
    end
    fire_c = (cnt >= thr);
  end

endmodule

// File: rtl/bnn_layer_seq.sv
// Sequential BNN layer: serial config chain, one shared neuron evaluated per
// cycle, atomic commit of the whole output vector.
module bnn_layer_seq
  import bnn_pkg::*;
#(
  parameter int unsigned N_IN  = 6,
  parameter int unsigned N_OUT = 8,
  parameter int unsigned LD_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             setup,
  input  logic [LD_W-1:0]  ld_data,
  input  logic [N_IN-1:0]  x,
  input  logic             x_valid,
  output logic             x_ready,
  output logic [N_OUT-1:0] y,
  output logic             y_valid,
  output logic             busy
);

  localparam int unsigned CNT_W = cnt_w(N_IN);
  localparam int unsigned REC   = rec_w(N_IN);
  localparam int unsigned TOTAL = N_OUT * REC;
  localparam int unsigned IDX_W = (N_OUT > 1) ? clog2(N_OUT) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_OUT - 1);

  state_t           state;
  state_t           next_state;
  logic [TOTAL-1:0] chain;
  logic [N_IN-1:0]  x_q;
  logic [IDX_W-1:0] idx;
  logic [N_OUT-1:0] scratch;
  logic [N_OUT-1:0] y_next_c;
  logic [REC-1:0]   recs_c [N_OUT];
  logic [REC-1:0]   rec_c;
  logic             fire_c;
  logic             accept_c;
  logic             commit_c;

  // Slice the chain into per-neuron {thr, w} records
  for (genvar j = 0; j < N_OUT; j++) begin : g_rec
    assign recs_c[j] = chain[j*REC +: REC];
  end

  assign rec_c = recs_c[idx];

  bnn_neuron #(
    .N_IN  (N_IN),
    .CNT_W (CNT_W)
  ) u_neuron (
    .x      (x_q),
    .w      (rec_c[N_IN-1:0]),
    .thr    (rec_c[REC-1:N_IN]),
    .fire_c (fire_c)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state and per-cycle control; setup overrides everything
  always_comb begin
    next_state = state;
    accept_c   = 1'b0;
    commit_c   = 1'b0;
    if (setup) begin
      next_state = LOAD;
    end else begin
      case (state)
        LOAD: next_state = IDLE;
        IDLE, DONE: begin
          if (x_valid && x_ready) begin
            accept_c   = 1'b1;
            next_state = EVAL;
          end
        end
        EVAL: begin
          if (idx == IDX_LAST) begin
            commit_c   = 1'b1;
            next_state = DONE;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Final result vector including the neuron evaluated this cycle
  always_comb begin
    y_next_c      = scratch;
    y_next_c[idx] = fire_c;
  end

  // Config chain, captured input, evaluation index and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain   <= '0;
      x_q     <= '0;
      idx     <= '0;
      scratch <= '0;
      y       <= '0;
      y_valid <= 1'b0;
      x_ready <= 1'b0;
      busy    <= 1'b0;
    end else begin
      x_ready <= (next_state == IDLE) || (next_state == DONE);
      busy    <= (next_state == EVAL);
      if (setup) begin
        chain   <= TOTAL'({chain, ld_data});
        y_valid <= 1'b0;
      end
      if (accept_c) begin
        x_q     <= x;
        idx     <= '0;
        y_valid <= 1'b0;
      end
      if ((state == EVAL) && !setup) begin
        scratch[idx] <= fire_c;
        idx          <= idx + IDX_W'(1);
      end
      if (commit_c) begin
        y       <= y_next_c;
        y_valid <= 1'b1;
        idx     <= '0;
      end
    end
  end

endmodule
